// File: rtl/m_dmem_ctrl.sv
// Data-memory controller: valid/ready request, fixed LATENCY, byte/half/word access with sign/zero extension.
// Optional `DMEM_RANGE_CHECK_EN: flag addresses beyond the array instead of wrapping.
module m_dmem_ctrl #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 1
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_we,
    input  logic [2:0]  w_req_funct3,
    input  logic [31:0] w_req_addr,
    input  logic [31:0] w_req_wdata,
    output logic        w_resp_valid,
    output logic [31:0] w_resp_rdata,
    output logic        w_resp_err
);

    localparam int         WORDS   = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);
    localparam bit         DIRECT  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        accept;
    logic        latch_en;
    logic        enter_resp;

    logic        lat_we;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_we;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]  boff;
    logic        acc_err;
    logic        misaligned;
    logic        illegal;
    logic        range_err;
    logic [3:0]  be;
    logic [31:0] wlane;
    logic        write_en;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] load_data;

    logic [31:0] mem [WORDS];

    assign w_req_ready = (state != ST_WAIT);
    assign accept      = w_req_valid & w_req_ready;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        latch_en   = 1'b0;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE, ST_RESP: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    latch_en   = 1'b1;
                    cnt_nxt    = LAT_M1;
                    state_nxt  = DIRECT ? ST_RESP : ST_WAIT;
                    enter_resp = DIRECT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt  = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // With LATENCY==1 the access completes on the accepting edge, straight from the request inputs.
    always_comb begin
        if (state == ST_WAIT) begin
            acc_we     = lat_we;
            acc_funct3 = lat_funct3;
            acc_addr   = lat_addr;
            acc_wdata  = lat_wdata;
        end else begin
            acc_we     = w_req_we;
            acc_funct3 = w_req_funct3;
            acc_addr   = w_req_addr;
            acc_wdata  = w_req_wdata;
        end
    end

    assign idx  = acc_addr[DEPTH_LOG2+1:2];
    assign boff = acc_addr[1:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (acc_funct3)
            3'b000:         illegal = 1'b0;
            3'b100:         illegal = acc_we;
            3'b001:         misaligned = boff[0];
            3'b101: begin
                illegal    = acc_we;
                misaligned = boff[0];
            end
            3'b010:         misaligned = (boff != 2'b00);
            default:        illegal = 1'b1;
        endcase
    end

`ifdef DMEM_RANGE_CHECK_EN
    assign range_err = |acc_addr[31:DEPTH_LOG2+2];
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^acc_addr[31:DEPTH_LOG2+2];
    assign range_err      = 1'b0;
`endif

    assign acc_err = illegal | misaligned | range_err;

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        be    = 4'b0000;
        wlane = acc_wdata;
        case (acc_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << boff;
                wlane = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be    = boff[1] ? 4'b1100 : 4'b0011;
                wlane = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wlane = acc_wdata;
            end
            default: be = 4'b0000;
        endcase
    end

    assign write_en = enter_resp & acc_we & ~acc_err;
    assign rword    = mem[idx];
    assign rshift   = rword >> {boff, 3'b000};

    always_comb begin
        case (acc_funct3)
            3'b000:  load_data = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  load_data = {24'h0, rshift[7:0]};
            3'b001:  load_data = {{16{rshift[15]}}, rshift[15:0]};
            3'b101:  load_data = {16'h0, rshift[15:0]};
            3'b010:  load_data = rword;
            default: load_data = 32'h0;
        endcase
        if (acc_err || acc_we) begin
            load_data = 32'h0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            lat_we       <= 1'b0;
            lat_funct3   <= 3'b000;
            lat_addr     <= 32'h0;
            lat_wdata    <= 32'h0;
            w_resp_valid <= 1'b0;
            w_resp_rdata <= 32'h0;
            w_resp_err   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            w_resp_valid <= enter_resp;
            if (latch_en) begin
                lat_we     <= w_req_we;
                lat_funct3 <= w_req_funct3;
                lat_addr   <= w_req_addr;
                lat_wdata  <= w_req_wdata;
            end
            if (enter_resp) begin
                w_resp_rdata <= load_data;
                w_resp_err   <= acc_err;
            end
        end
    end

    // NOTE: the array has no reset; a reset only drops the pending access, it never clears contents.
    always_ff @(posedge w_clk) begin
        if (write_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    a_err_zero: assert property (@(posedge w_clk) disable iff (!w_rst_n)
        (w_resp_valid && w_resp_err) |-> (w_resp_rdata == 32'h0));

    if (LATENCY > 1) begin : g_pulse_chk
        a_resp_pulse: assert property (@(posedge w_clk) disable iff (!w_rst_n)
            w_resp_valid |=> !w_resp_valid);
    end

endmodule

// File: tb/tb_m_dmem_ctrl.sv
// Bench for m_dmem_ctrl: two instances (LATENCY 1 and 3) checked against a byte-addressed memory model.
module tb_m_dmem_ctrl;

    localparam int DEPTH_LOG2 = 6;
    localparam int NBYTES     = 4 << DEPTH_LOG2;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mb [2][NBYTES];

    always #5 w_clk = ~w_clk;

    m_dmem_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(1)) dut1 (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .w_req_valid(req_valid[0]), .w_req_ready(req_ready[0]), .w_req_we(req_we[0]),
        .w_req_funct3(req_funct3[0]), .w_req_addr(req_addr[0]), .w_req_wdata(req_wdata[0]),
        .w_resp_valid(resp_valid[0]), .w_resp_rdata(resp_rdata[0]), .w_resp_err(resp_err[0])
    );

    m_dmem_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .LATENCY(3)) dut3 (
        .w_clk(w_clk), .w_rst_n(w_rst_n),
        .w_req_valid(req_valid[1]), .w_req_ready(req_ready[1]), .w_req_we(req_we[1]),
        .w_req_funct3(req_funct3[1]), .w_req_addr(req_addr[1]), .w_req_wdata(req_wdata[1]),
        .w_resp_valid(resp_valid[1]), .w_resp_rdata(resp_rdata[1]), .w_resp_err(resp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: memory as a flat byte array, access rules applied directly by size and signedness.
    function automatic void model(input int d, input bit we, input bit [2:0] f3,
                                  input bit [31:0] addr, input bit [31:0] wdata,
                                  output bit [31:0] rdata, output bit err);
        int size;
        int unsigned a;
        bit [31:0] v;
        rdata = 32'h0;
        err   = 1'b0;
        v     = 32'h0;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        if (size == 0 || (we && f3 >= 3'd4)) err = 1'b1;
        else if ((addr % size) != 0) err = 1'b1;
`ifdef DMEM_RANGE_CHECK_EN
        if (addr >= NBYTES) err = 1'b1;
`endif
        if (err) return;
        a = addr % NBYTES;
        if (we) begin
            for (int i = 0; i < size; i++) mb[d][a + i] = wdata[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) v[8*i +: 8] = mb[d][a + i];
            if (f3 == 3'd0 && v[7])  v = v | 32'hffffff00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hffff0000;
            rdata = v;
        end
    endfunction

    // Entered #1 after an edge; returns #1 after the edge on which the response is visible.
    task automatic do_access(input int d, input bit we, input bit [2:0] f3,
                             input bit [31:0] addr, input bit [31:0] wdata, input string tag);
        bit [31:0] er;
        bit        ee;
        int        waited;
        int        lat;
        lat           = (d == 0) ? 1 : 3;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        req_valid[d]  = 1'b1;
        waited = 0;
        while (!req_ready[d] && waited < 20) begin
            @(posedge w_clk); #1;
            waited++;
        end
        if (!req_ready[d]) begin
            check({tag, " ready timeout"}, 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge w_clk); #1;
        req_valid[d] = 1'b0;
        model(d, we, f3, addr, wdata, er, ee);
        waited = 0;
        while (!resp_valid[d] && waited < 20) begin
            check({tag, " ready in wait"}, 32'(req_ready[d]), 32'd0);
            @(posedge w_clk); #1;
            waited++;
        end
        check({tag, " latency"}, 32'(waited), 32'(lat - 1));
        check({tag, " valid"}, 32'(resp_valid[d]), 32'd1);
        check({tag, " rdata"}, resp_rdata[d], er);
        check({tag, " err"}, 32'(resp_err[d]), 32'(ee));
    endtask

    initial begin
        bit [31:0] er;
        bit        ee;
        bit [31:0] rnd;
        bit [31:0] a;
        bit [2:0]  f;
        bit        w;

        w_rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = 3'b0;
            req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        repeat (3) @(posedge w_clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset ready", 32'(req_ready[d]), 32'd1);
            check("reset valid", 32'(resp_valid[d]), 32'd0);
            check("reset rdata", resp_rdata[d], 32'h0);
            check("reset err", 32'(resp_err[d]), 32'd0);
        end
        w_rst_n = 1'b1;

        // Give every word a known value so the model never holds unknowns.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NBYTES / 4; i++)
                do_access(d, 1'b1, 3'b010, 32'(i * 4), $urandom, "init sw");

        do_access(0, 1'b1, 3'b010, 32'h10, 32'h8badf00d, "t1 sw");
        do_access(0, 1'b0, 3'b010, 32'h10, 32'h0, "t1 lw");
        check("t1 lw const", resp_rdata[0], 32'h8badf00d);

        do_access(0, 1'b1, 3'b000, 32'h11, 32'h00000080, "t2 sb");
        do_access(0, 1'b0, 3'b000, 32'h11, 32'h0, "t2 lb");
        check("t2 lb const", resp_rdata[0], 32'hffffff80);
        do_access(0, 1'b0, 3'b100, 32'h11, 32'h0, "t2 lbu");
        check("t2 lbu const", resp_rdata[0], 32'h00000080);
        do_access(0, 1'b0, 3'b010, 32'h10, 32'h0, "t2 lw");
        check("t2 lw const", resp_rdata[0], 32'h8bad800d);

        do_access(0, 1'b0, 3'b001, 32'h13, 32'h0, "t4 lh mis");
        check("t4 lh err const", 32'(resp_err[0]), 32'd1);
        do_access(0, 1'b1, 3'b010, 32'h12, 32'hdeadbeef, "t4 sw mis");
        do_access(0, 1'b0, 3'b010, 32'h10, 32'h0, "t4 lw");
        check("t4 unchanged const", resp_rdata[0], 32'h8bad800d);
        do_access(0, 1'b0, 3'b011, 32'h10, 32'h0, "t4 f3 011");
        do_access(0, 1'b1, 3'b100, 32'h10, 32'h12345678, "t4 store f3 100");
        do_access(0, 1'b0, 3'b101, 32'h12, 32'h0, "t4 lhu");

        // Back-to-back on LATENCY=3 with the second request held valid through the wait.
        do_access(1, 1'b1, 3'b010, 32'h20, $urandom, "t3 pre");
        rnd = $urandom;
        req_we[1] = 1'b0; req_funct3[1] = 3'b010; req_addr[1] = 32'h20; req_valid[1] = 1'b1;
        @(posedge w_clk); #1;
        model(1, 1'b0, 3'b010, 32'h20, 32'h0, er, ee);
        req_we[1] = 1'b1; req_funct3[1] = 3'b001; req_addr[1] = 32'h22; req_wdata[1] = rnd;
        check("t3 c1 ready", 32'(req_ready[1]), 32'd0);
        check("t3 c1 valid", 32'(resp_valid[1]), 32'd0);
        @(posedge w_clk); #1;
        check("t3 c2 ready", 32'(req_ready[1]), 32'd0);
        check("t3 c2 valid", 32'(resp_valid[1]), 32'd0);
        @(posedge w_clk); #1;
        check("t3 c3 valid", 32'(resp_valid[1]), 32'd1);
        check("t3 c3 ready", 32'(req_ready[1]), 32'd1);
        check("t3 c3 rdata", resp_rdata[1], er);
        @(posedge w_clk); #1;
        req_valid[1] = 1'b0;
        model(1, 1'b1, 3'b001, 32'h22, rnd, er, ee);
        check("t3 c4 valid", 32'(resp_valid[1]), 32'd0);
        check("t3 c4 ready", 32'(req_ready[1]), 32'd0);
        @(posedge w_clk); #1;
        check("t3 c5 valid", 32'(resp_valid[1]), 32'd0);
        @(posedge w_clk); #1;
        check("t3 c6 valid", 32'(resp_valid[1]), 32'd1);
        check("t3 c6 err", 32'(resp_err[1]), 32'd0);
        check("t3 c6 rdata", resp_rdata[1], 32'h0);
        @(posedge w_clk); #1;
        check("t3 idle valid", 32'(resp_valid[1]), 32'd0);
        check("t3 idle ready", 32'(req_ready[1]), 32'd1);
        do_access(1, 1'b0, 3'b010, 32'h20, 32'h0, "t3 lw merge");

        // Reset while an SW sits in WAIT: nothing completes and the word keeps its old value.
        req_we[1] = 1'b1; req_funct3[1] = 3'b010; req_addr[1] = 32'h30;
        req_wdata[1] = ~{mb[1][51], mb[1][50], mb[1][49], mb[1][48]};
        req_valid[1] = 1'b1;
        @(posedge w_clk); #1;
        req_valid[1] = 1'b0;
        @(posedge w_clk); #1;
        w_rst_n = 1'b0;
        #1;
        check("t5 rst ready", 32'(req_ready[1]), 32'd1);
        check("t5 rst valid", 32'(resp_valid[1]), 32'd0);
        repeat (2) @(posedge w_clk);
        #1;
        w_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge w_clk); #1;
            check("t5 no pulse", 32'(resp_valid[1]), 32'd0);
        end
        do_access(1, 1'b0, 3'b010, 32'h30, 32'h0, "t5 lw old");

        for (int d = 0; d < 2; d++) begin
            do_access(d, 1'b1, 3'b010, 32'h100, $urandom, "t6 sw wrap");
            do_access(d, 1'b0, 3'b010, 32'h0, 32'h0, "t6 lw 0");
            do_access(d, 1'b0, 3'b000, 32'h8000_0003, 32'h0, "t6 lb high");
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                w = 1'($urandom_range(0, 1));
                f = 3'($urandom_range(0, 7));
                a = 32'($urandom_range(0, NBYTES - 1));
                if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
                if ($urandom_range(0, 7) == 0) a = a | ($urandom << DEPTH_LOG2 + 2);
                do_access(d, w, f, a, $urandom, "rand");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
